// File: rtl/baseball_pkg.sv
// Shared sizing constants for the baseball guess-tracking blocks.
package baseball_pkg;

    localparam int PLAYER_CNT  = 2;
    localparam int GUESS_CNT_W = 3;

endpackage

// File: rtl/button_signal_multi_if.sv
// Button tracker bundle: qualifying inputs from the decoder, debounced events to the game FSM.
interface button_signal_multi_if
    import baseball_pkg::*;
#(
    parameter int NUM_CH = PLAYER_CNT,
    parameter int CNT_W  = GUESS_CNT_W
);

    logic                    guess_mode;
    logic [NUM_CH-1:0]       input_sig;
    logic                    cnt_clr;
    logic [NUM_CH-1:0]       btn_held;
    logic [NUM_CH-1:0]       btn_pressed;
    logic [NUM_CH-1:0]       btn_released;
    logic [NUM_CH*CNT_W-1:0] press_cnt;
    logic [NUM_CH*CNT_W-1:0] release_cnt;
    logic                    any_pressed;

    modport master (
        output guess_mode, input_sig, cnt_clr,
        input  btn_held, btn_pressed, btn_released, press_cnt, release_cnt, any_pressed
    );

    modport slave (
        input  guess_mode, input_sig, cnt_clr,
        output btn_held, btn_pressed, btn_released, press_cnt, release_cnt, any_pressed
    );

endinterface

// File: rtl/btn_channel.sv
// One button channel: input register, optional debouncer, edge pulses and
// press/release counters with wrap or saturate.
module btn_channel #(
    parameter int DEBOUNCE_CYC = 0,
    parameter int CNT_W        = 3,
    parameter int SATURATE     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q,
    input  logic             cnt_clr,
    output logic             held,
    output logic             pressed,
    output logic             released,
    output logic [CNT_W-1:0] press_cnt,
    output logic [CNT_W-1:0] release_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic samp;
    logic stable;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp <= 1'b0;
            prev <= 1'b0;
        end else begin
            samp <= q;
            prev <= stable;
        end
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stable <= 1'b0;
                else     stable <= samp;
            end
        end else begin : g_debounce
            localparam int             DW   = $clog2(DEBOUNCE_CYC + 1);
            localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYC - 1);
            logic [DW-1:0] dcnt;

            // Any return to the accepted level restarts the stability count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dcnt   <= '0;
                    stable <= 1'b0;
                end else if (samp == stable) begin
                    dcnt <= '0;
                end else if (dcnt == LAST) begin
                    stable <= ~stable;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    endgenerate

    assign held     = stable;
    assign pressed  = stable & ~prev;
    assign released = ~stable & prev;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
        if (SATURATE != 0 && c == CNT_MAX) return c;
        return c + 1'b1;
    endfunction

    // Clear wins over a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_cnt   <= '0;
            release_cnt <= '0;
        end else if (cnt_clr) begin
            press_cnt   <= '0;
            release_cnt <= '0;
        end else begin
            if (pressed)  press_cnt   <= bump(press_cnt);
            if (released) release_cnt <= bump(release_cnt);
        end
    end

endmodule

// File: rtl/button_signal_multi.sv
// Multi-channel guess-button tracker: qualifies raw lines with guess_mode and the
// one-hot rule, then hands each line to its own debounce/count channel.
module button_signal_multi
    import baseball_pkg::*;
#(
    parameter int NUM_CH       = PLAYER_CNT,
    parameter int CNT_W        = GUESS_CNT_W,
    parameter int DEBOUNCE_CYC = 0,
    parameter int SATURATE     = 0,
    parameter int ONEHOT_ONLY  = 1
) (
    input logic                  clk,
    input logic                  rst,
    button_signal_multi_if.slave bus
);

    localparam logic [NUM_CH-1:0] BIT0 = NUM_CH'(1);

    logic [NUM_CH-1:0]       q;
    logic [NUM_CH-1:0]       held;
    logic [NUM_CH-1:0]       pressed;
    logic [NUM_CH-1:0]       released;
    logic [NUM_CH*CNT_W-1:0] press_all;
    logic [NUM_CH*CNT_W-1:0] release_all;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            // With the one-hot rule, simultaneous buttons void every channel.
            assign q[i] = bus.guess_mode & bus.input_sig[i] &
                          ((ONEHOT_ONLY == 0) || (bus.input_sig == (BIT0 << i)));

            btn_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .CNT_W        (CNT_W),
                .SATURATE     (SATURATE)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .q           (q[i]),
                .cnt_clr     (bus.cnt_clr),
                .held        (held[i]),
                .pressed     (pressed[i]),
                .released    (released[i]),
                .press_cnt   (press_all[i*CNT_W +: CNT_W]),
                .release_cnt (release_all[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.btn_held     = held;
    assign bus.btn_pressed  = pressed;
    assign bus.btn_released = released;
    assign bus.press_cnt    = press_all;
    assign bus.release_cnt  = release_all;
    assign bus.any_pressed  = |pressed;

endmodule

// File: tb/tb_button_signal_multi.sv
// Directed bench: four tracker variants (defaults, no one-hot rule, saturating,
// 4-cycle debounce) share one stimulus and are checked against hand-computed values.
module tb_button_signal_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       guess_mode = 1'b0;
    logic [1:0] input_sig = 2'b00;
    logic       cnt_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_signal_multi_if #(.NUM_CH(2), .CNT_W(3)) if_def ();
    button_signal_multi_if #(.NUM_CH(2), .CNT_W(3)) if_noh ();
    button_signal_multi_if #(.NUM_CH(2), .CNT_W(3)) if_sat ();
    button_signal_multi_if #(.NUM_CH(2), .CNT_W(3)) if_db ();

    assign if_def.guess_mode = guess_mode;
    assign if_def.input_sig  = input_sig;
    assign if_def.cnt_clr    = cnt_clr;
    assign if_noh.guess_mode = guess_mode;
    assign if_noh.input_sig  = input_sig;
    assign if_noh.cnt_clr    = cnt_clr;
    assign if_sat.guess_mode = guess_mode;
    assign if_sat.input_sig  = input_sig;
    assign if_sat.cnt_clr    = cnt_clr;
    assign if_db.guess_mode  = guess_mode;
    assign if_db.input_sig   = input_sig;
    assign if_db.cnt_clr     = cnt_clr;

    button_signal_multi u_def (.clk(clk), .rst(rst), .bus(if_def));
    button_signal_multi #(.ONEHOT_ONLY(0)) u_noh (.clk(clk), .rst(rst), .bus(if_noh));
    button_signal_multi #(.SATURATE(1)) u_sat (.clk(clk), .rst(rst), .bus(if_sat));
    button_signal_multi #(.DEBOUNCE_CYC(4)) u_db (.clk(clk), .rst(rst), .bus(if_db));

    logic [1:0] pr [4];
    logic [1:0] rl [4];
    logic       ap [4];

    assign pr[0] = if_def.btn_pressed;
    assign pr[1] = if_noh.btn_pressed;
    assign pr[2] = if_sat.btn_pressed;
    assign pr[3] = if_db.btn_pressed;
    assign rl[0] = if_def.btn_released;
    assign rl[1] = if_noh.btn_released;
    assign rl[2] = if_sat.btn_released;
    assign rl[3] = if_db.btn_released;
    assign ap[0] = if_def.any_pressed;
    assign ap[1] = if_noh.any_pressed;
    assign ap[2] = if_sat.any_pressed;
    assign ap[3] = if_db.any_pressed;

    // Pulse tallies per instance/channel since the last clear_acc.
    int pp [4][2];
    int rp [4][2];
    int ap_n [4];
    int first_pr [4];
    int cyc;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_acc();
        cyc = 0;
        for (int j = 0; j < 4; j++) begin
            ap_n[j]     = 0;
            first_pr[j] = -1;
            for (int c = 0; c < 2; c++) begin
                pp[j][c] = 0;
                rp[j][c] = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int j = 0; j < 4; j++) begin
                for (int c = 0; c < 2; c++) begin
                    if (pr[j][c]) pp[j][c]++;
                    if (rl[j][c]) rp[j][c]++;
                end
                if (ap[j]) ap_n[j]++;
                if (pr[j][0] && first_pr[j] < 0) first_pr[j] = cyc;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        guess_mode = 1'b0;
        input_sig  = 2'b00;
        cnt_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_acc();
    endtask

    initial begin
        do_reset();
        check("reset held",        int'(if_def.btn_held), 0);
        check("reset pressed",     int'(if_def.btn_pressed), 0);
        check("reset any_pressed", int'(if_def.any_pressed), 0);
        check("reset press_cnt",   int'(if_def.press_cnt), 0);
        check("reset release_cnt", int'(if_def.release_cnt), 0);

        // Single press on channel 0, three cycles long.
        guess_mode = 1'b1;
        input_sig  = 2'b01;
        run(3);
        input_sig = 2'b00;
        run(6);
        check("t1 press pulses ch0",   pp[0][0], 1);
        check("t1 release pulses ch0", rp[0][0], 1);
        check("t1 press pulses ch1",   pp[0][1], 0);
        check("t1 any_pressed pulses", ap_n[0], 1);
        check("t1 press_cnt ch0",      int'(if_def.press_cnt[2:0]), 1);
        check("t1 release_cnt ch0",    int'(if_def.release_cnt[2:0]), 1);
        check("t1 press_cnt ch1",      int'(if_def.press_cnt[5:3]), 0);
        check("t1 release_cnt ch1",    int'(if_def.release_cnt[5:3]), 0);

        // Both buttons together: voided by the one-hot rule, counted without it.
        do_reset();
        guess_mode = 1'b1;
        input_sig  = 2'b11;
        run(3);
        input_sig = 2'b00;
        run(6);
        check("t2 onehot pulses ch0",   pp[0][0], 0);
        check("t2 onehot pulses ch1",   pp[0][1], 0);
        check("t2 onehot press_cnt",    int'(if_def.press_cnt), 0);
        check("t2 free press_cnt ch0",  int'(if_noh.press_cnt[2:0]), 1);
        check("t2 free press_cnt ch1",  int'(if_noh.press_cnt[5:3]), 1);
        check("t2 free release_cnt ch1", int'(if_noh.release_cnt[5:3]), 1);
        check("t2 free any_pressed",    ap_n[1], 1);

        // Nine short presses: wrap versus saturate; too short for the debounced variant.
        do_reset();
        guess_mode = 1'b1;
        for (int n = 0; n < 9; n++) begin
            input_sig = 2'b01;
            run(2);
            input_sig = 2'b00;
            run(2);
        end
        run(4);
        check("t3 wrap press_cnt",    int'(if_def.press_cnt[2:0]), 1);
        check("t3 wrap release_cnt",  int'(if_def.release_cnt[2:0]), 1);
        check("t3 sat press_cnt",     int'(if_sat.press_cnt[2:0]), 7);
        check("t3 sat release_cnt",   int'(if_sat.release_cnt[2:0]), 7);
        check("t3 wrap press pulses", pp[0][0], 9);
        check("t3 debounce press_cnt", int'(if_db.press_cnt[2:0]), 0);

        // Debounce: 3-cycle glitch rejected, 6-cycle press accepted with fixed latency.
        do_reset();
        guess_mode = 1'b1;
        input_sig  = 2'b01;
        run(3);
        input_sig = 2'b00;
        run(10);
        check("t4 glitch pulses",    pp[3][0], 0);
        check("t4 glitch press_cnt", int'(if_db.press_cnt[2:0]), 0);
        check("t4 glitch held",      int'(if_db.btn_held), 0);
        clear_acc();
        input_sig = 2'b01;
        run(6);
        input_sig = 2'b00;
        run(12);
        check("t4 press pulses",     pp[3][0], 1);
        check("t4 release pulses",   rp[3][0], 1);
        check("t4 press latency",    first_pr[3], 5);
        check("t4 bypass latency",   first_pr[0], 2);
        check("t4 press_cnt",        int'(if_db.press_cnt[2:0]), 1);
        check("t4 release_cnt",      int'(if_db.release_cnt[2:0]), 1);

        // Clear colliding with a press, then guess_mode dropped while held.
        do_reset();
        guess_mode = 1'b1;
        input_sig  = 2'b01;
        run(2);
        check("t5 pressed before clr", int'(if_def.btn_pressed), 1);
        cnt_clr = 1'b1;
        run(1);
        cnt_clr = 1'b0;
        check("t5 press_cnt after clr", int'(if_def.press_cnt[2:0]), 0);
        check("t5 held after clr",      int'(if_def.btn_held), 1);
        clear_acc();
        guess_mode = 1'b0;
        run(6);
        check("t5 mode-drop release pulses", rp[0][0], 1);
        check("t5 mode-drop release_cnt",    int'(if_def.release_cnt[2:0]), 1);
        check("t5 mode-drop held",           int'(if_def.btn_held), 0);
        check("t5 mode-drop press_cnt",      int'(if_def.press_cnt[2:0]), 0);

        // Reset in the middle of a held press, then release reset still holding.
        do_reset();
        guess_mode = 1'b1;
        input_sig  = 2'b01;
        run(4);
        check("t6 held before rst",      int'(if_def.btn_held), 1);
        check("t6 press_cnt before rst", int'(if_def.press_cnt[2:0]), 1);
        rst = 1'b1;
        #1;
        check("t6 held in rst",      int'(if_def.btn_held), 0);
        check("t6 press_cnt in rst", int'(if_def.press_cnt), 0);
        check("t6 pressed in rst",   int'(if_def.btn_pressed), 0);
        check("t6 any in rst",       int'(if_def.any_pressed), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_acc();
        run(5);
        check("t6 fresh press pulses", pp[0][0], 1);
        check("t6 fresh press_cnt",    int'(if_def.press_cnt[2:0]), 1);
        check("t6 held after rst",     int'(if_def.btn_held), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
